// File: rtl/pad_cond_pkg.sv
// rtl/pad_cond_pkg.sv - shared types and sizing helpers for the pad input conditioner
package pad_cond_pkg;

    // Edge detected by a debouncer on a given sample tick.
    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_t;

    // Width of the per-bit stability counter; never narrower than one bit.
    function automatic int cnt_width(input int stable_samples);
        int w;
        w = $clog2(stable_samples);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pad_debounce_bit.sv
// rtl/pad_debounce_bit.sv - synchronizer, debouncer, edge pulses and sticky change flag for one pad
//
// Ports:
//   clk, rst_n    core clock, asynchronous active-low reset
//   tick          shared debounce sample strobe
//   pad_in        raw pad level, asynchronous to clk
//   chg_clr       clear strobe for chg_pending
//   input_sync    synchronized level
//   input_db      debounced level
//   input_rise    one-cycle pulse on input_db 0->1
//   input_fall    one-cycle pulse on input_db 1->0
//   chg_pending   sticky flag: an edge occurred since the last clear
module pad_debounce_bit
    import pad_cond_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pad_in,
    input  logic chg_clr,
    output logic input_sync,
    output logic input_db,
    output logic input_rise,
    output logic input_fall,
    output logic chg_pending
);

    localparam int             CW       = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   db_q;
    logic                   db_d;
    logic                   rise_q;
    logic                   fall_q;
    logic                   chg_q;
    edge_t                  edge_evt;

    assign input_sync  = sync_q[SYNC_STAGES-1];
    assign input_db    = db_q;
    assign input_rise  = rise_q;
    assign input_fall  = fall_q;
    assign chg_pending = chg_q;

    always_comb begin
        cnt_d    = cnt_q;
        db_d     = db_q;
        edge_evt = EDGE_NONE;
        if (tick) begin
            if (input_sync == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d     = input_sync;
                cnt_d    = '0;
                edge_evt = input_sync ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= (edge_evt == EDGE_RISE);
            fall_q <= (edge_evt == EDGE_FALL);
            // Set wins over clear both on the edge itself and while its pulse is
            // visible, so a clear issued alongside an observed pulse cannot lose it.
            chg_q  <= (edge_evt != EDGE_NONE) | rise_q | fall_q | (chg_q & ~chg_clr);
        end
    end

endmodule

// File: rtl/pad_input_conditioner.sv
// rtl/pad_input_conditioner.sv - pad-ring to core conditioner: reset sync, input sync, debounce, edges
//
// Ports:
//   clk          core clock
//   rst_n        raw asynchronous active-low reset
//   input_in     raw pad inputs
//   chg_clr      per-bit clear for chg_pending
//   rst_n_core   reset for chip_core, async assert / sync deassert
//   input_sync   synchronized inputs
//   input_db     debounced inputs
//   input_rise   one-cycle rise pulses of input_db
//   input_fall   one-cycle fall pulses of input_db
//   chg_pending  sticky per-bit change flags
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int NUM_INPUT_PADS = 68,
    parameter int SYNC_STAGES    = 2,
    parameter int PRESCALE       = 256,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_INPUT_PADS-1:0] input_in,
    input  logic [NUM_INPUT_PADS-1:0] chg_clr,
    output logic                      rst_n_core,
    output logic [NUM_INPUT_PADS-1:0] input_sync,
    output logic [NUM_INPUT_PADS-1:0] input_db,
    output logic [NUM_INPUT_PADS-1:0] input_rise,
    output logic [NUM_INPUT_PADS-1:0] input_fall,
    output logic [NUM_INPUT_PADS-1:0] chg_pending
);

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic                   tick;

    // Shifts in ones after release; cleared asynchronously whenever rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_core = rst_sync_q[SYNC_STAGES-1];

    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign tick = 1'b1;
        end else begin : g_prescale
            localparam int            PW       = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] pre_q;

            assign tick = (pre_q == PRE_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pre_q <= '0;
                end else if (tick) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_INPUT_PADS; i++) begin : g_bit
            pad_debounce_bit #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_SAMPLES(STABLE_SAMPLES)
            ) u_bit (
                .clk        (clk),
                .rst_n      (rst_n),
                .tick       (tick),
                .pad_in     (input_in[i]),
                .chg_clr    (chg_clr[i]),
                .input_sync (input_sync[i]),
                .input_db   (input_db[i]),
                .input_rise (input_rise[i]),
                .input_fall (input_fall[i]),
                .chg_pending(chg_pending[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pad_input_conditioner.sv
// tb/tb_pad_input_conditioner.sv - self-checking bench for pad_input_conditioner
module tb_pad_input_conditioner;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in0, clr0, in8, clr8;
    logic         rc0, rc8;
    logic [N-1:0] sync0, db0, rise0, fall0, chg0;
    logic [N-1:0] sync8, db8, rise8, fall8, chg8;

    always #5 clk = ~clk;

    pad_input_conditioner #(
        .NUM_INPUT_PADS(N), .SYNC_STAGES(2), .PRESCALE(1), .STABLE_SAMPLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .input_in(in0), .chg_clr(clr0),
        .rst_n_core(rc0), .input_sync(sync0), .input_db(db0),
        .input_rise(rise0), .input_fall(fall0), .chg_pending(chg0)
    );

    pad_input_conditioner #(
        .NUM_INPUT_PADS(N), .SYNC_STAGES(2), .PRESCALE(8), .STABLE_SAMPLES(4)
    ) dut_ps8 (
        .clk(clk), .rst_n(rst_n), .input_in(in8), .chg_clr(clr8),
        .rst_n_core(rc8), .input_sync(sync8), .input_db(db8),
        .input_rise(rise8), .input_fall(fall8), .chg_pending(chg8)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          base;
    logic [31:0] sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event word: {instance, bit, kind(1=rise,2=fall), cycle}
    function automatic logic [31:0] ev(input int d, input int b, input int kind, input int c);
        return {4'(d), 4'(b), 4'(kind), 20'(c)};
    endfunction

    task automatic observe(input int d, input int b, input int kind);
        if (sb_q.size() == 0) check_eq("unexpected_edge", ev(d, b, kind, cyc), 32'h0);
        else                  check_eq("edge_event", ev(d, b, kind, cyc), sb_q.pop_front());
    endtask

    always @(negedge clk) begin
        for (int b = 0; b < N; b++) begin
            if (rise0[b]) observe(0, b, 1);
            if (fall0[b]) observe(0, b, 2);
        end
        for (int b = 0; b < N; b++) begin
            if (rise8[b]) observe(1, b, 1);
            if (fall8[b]) observe(1, b, 2);
        end
    end

    // Cycle at which the PRESCALE=8 instance shows an edge for an input driven at cycle c0.
    function automatic int ps8_edge_cycle(input int c0);
        int k;
        int hits;
        k    = c0 + 3 - base;
        hits = 0;
        while (1) begin
            if (k % 8 == 0) begin
                hits++;
                if (hits == 4) break;
            end
            k++;
        end
        return base + k;
    endfunction

    initial begin
        int c0;
        int exp_c;
        rst_n = 1'b0;
        in0 = '0; clr0 = '0; in8 = '0; clr8 = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_rst_core", {30'd0, rc0, rc8}, 32'd0);
        check_eq("reset_outputs", {sync0, db0, rise0, fall0, chg0, sync8, db8, chg8}, 32'd0);

        // Reset release: rst_n_core rises on the second edge.
        rst_n = 1'b1;
        base  = cyc;
        @(negedge clk);
        check_eq("rst_sync_edge1", {30'd0, rc0, rc8}, 32'd0);
        @(negedge clk);
        check_eq("rst_sync_edge2", {30'd0, rc0, rc8}, 32'd3);

        // Clean rising edge on bit 2.
        @(negedge clk);
        c0 = cyc;
        in0[2] = 1'b1;
        sb_q.push_back(ev(0, 2, 1, c0 + 6));
        @(negedge clk);
        check_eq("sync_lat1", 32'(sync0[2]), 32'd0);
        @(negedge clk);
        check_eq("sync_lat2", 32'(sync0[2]), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("db_before", 32'(db0[2]), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("db_after", 32'(db0), 32'h4);
        check_eq("chg_after_rise", 32'(chg0), 32'h4);

        // Three-cycle glitch on bit 1 is rejected.
        @(negedge clk);
        in0[1] = 1'b1;
        repeat (3) @(negedge clk);
        in0[1] = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("glitch_db", 32'(db0), 32'h4);
        check_eq("glitch_chg", 32'(chg0), 32'h4);

        // Clear, then rise and fall on bit 3 with a clear racing the fall.
        clr0[2] = 1'b1;
        @(negedge clk);
        clr0[2] = 1'b0;
        check_eq("chg_clear", 32'(chg0), 32'h0);
        c0 = cyc;
        in0[3] = 1'b1;
        sb_q.push_back(ev(0, 3, 1, c0 + 6));
        repeat (8) @(negedge clk);
        check_eq("chg_bit3_rise", 32'(chg0), 32'h8);
        clr0[3] = 1'b1;
        @(negedge clk);
        clr0[3] = 1'b0;
        check_eq("chg_bit3_clr", 32'(chg0), 32'h0);
        c0 = cyc;
        in0[3] = 1'b0;
        sb_q.push_back(ev(0, 3, 2, c0 + 6));
        repeat (6) @(negedge clk);
        check_eq("fall_visible", 32'(fall0[3]), 32'd1);
        clr0[3] = 1'b1;
        @(negedge clk);
        clr0[3] = 1'b0;
        check_eq("clr_race_set_wins", 32'(chg0[3]), 32'd1);
        clr0[3] = 1'b1;
        @(negedge clk);
        clr0[3] = 1'b0;
        check_eq("clr_later", 32'(chg0[3]), 32'd0);

        // Reset dropped mid-cycle clears everything at once.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midreset_rst_core", {30'd0, rc0, rc8}, 32'd0);
        check_eq("midreset_outputs", {sync0, db0, rise0, fall0, chg0, 12'd0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        sb_q.push_back(ev(0, 2, 1, base + 6));
        @(negedge clk);
        check_eq("rerelease_edge1", {30'd0, rc0, rc8}, 32'd0);
        @(negedge clk);
        check_eq("rerelease_edge2", {30'd0, rc0, rc8}, 32'd3);
        repeat (6) @(negedge clk);
        check_eq("rerelease_db", 32'(db0), 32'h4);

        // Reset while bit 1 is part-way through debounce.
        @(negedge clk);
        c0 = cyc;
        in0[1] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        check_eq("middb_reset_db", 32'(db0), 32'h0);
        sb_q.push_back(ev(0, 1, 1, base + 6));
        sb_q.push_back(ev(0, 2, 1, base + 6));
        repeat (8) @(negedge clk);
        check_eq("middb_db", 32'(db0), 32'h6);

        // PRESCALE=8: edges land on the fourth tick after the sync change.
        c0 = cyc;
        in8[0] = 1'b1;
        exp_c = ps8_edge_cycle(c0);
        sb_q.push_back(ev(1, 0, 1, exp_c));
        while (cyc < exp_c - 1) @(negedge clk);
        check_eq("ps8_rise_early", 32'(db8[0]), 32'd0);
        @(negedge clk);
        check_eq("ps8_rise_db", 32'(db8[0]), 32'd1);
        @(negedge clk);
        check_eq("ps8_rise_width", 32'(rise8[0]), 32'd0);
        c0 = cyc;
        in8[0] = 1'b0;
        exp_c = ps8_edge_cycle(c0);
        sb_q.push_back(ev(1, 0, 2, exp_c));
        while (cyc < exp_c - 1) @(negedge clk);
        check_eq("ps8_fall_early", 32'(db8[0]), 32'd1);
        @(negedge clk);
        check_eq("ps8_fall_db", 32'(db8[0]), 32'd0);
        @(negedge clk);
        check_eq("ps8_fall_width", 32'(fall8[0]), 32'd0);
        check_eq("ps8_chg", 32'(chg8), 32'h1);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
